// File: rtl/binary_divmod.sv
// binary_divmod: multi-cycle restoring divider, one quotient bit per clock.
// The dividend shift register doubles as the working quotient as bits shift in.
module binary_divmod #(
   parameter int SIZE = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid,
   input  logic [2*SIZE-1:0] dividend,
   input  logic [SIZE-1:0]   divisor,
   output logic              busy,
   output logic              ready,
   output logic [2*SIZE-1:0] quotient,
   output logic [SIZE-1:0]   remainder,
   output logic              div_by_zero
);
   localparam int CW = $clog2(2*SIZE);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*SIZE-1:0] work_q, work_d, quot_q, quot_d;
   logic [SIZE-1:0]   dvs_q, dvs_d, rem_q, rem_d;
   logic [SIZE:0]     part_q, part_d, part_sh, part_sub;
   logic              dbz_q, dbz_d, ge;
   always_comb begin
      part_sh  = {part_q[SIZE-1:0], work_q[2*SIZE-1]};
      ge       = part_sh >= {1'b0, dvs_q};
      part_sub = part_sh - {1'b0, dvs_q};
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvs_d    = dvs_q;
      part_d   = part_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      if (state_q == RUN) begin
         part_d = ge ? part_sub : part_sh;
         work_d = {work_q[2*SIZE-2:0], ge};
         cnt_d  = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
         if (cnt_q == '0) begin
            state_d = DONE;
            quot_d  = work_d;
            rem_d   = part_d[SIZE-1:0];
            dbz_d   = 1'b0;
         end
      end else if (valid) begin
         // Zero divisor skips the iteration and reports a saturated quotient.
         if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend[SIZE-1:0];
            dbz_d   = 1'b1;
         end else begin
            state_d = RUN;
            work_d  = dividend;
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = CW'(2*SIZE-1);
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         dvs_q   <= '0;
         part_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         dvs_q   <= dvs_d;
         part_q  <= part_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end
   assign busy        = state_q == RUN;
   assign ready       = state_q == DONE;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule
